// File: rtl/ps2_direction_decoder.sv
// rtl/ps2_direction_decoder.sv - PS/2 keyboard frame receiver and arrow/WASD direction decoder
// Holds the last pressed direction as a one-hot code for the game datapath.
module ps2_direction_decoder #(
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [4:0] direction,
  output logic       dir_valid,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic          clk_m, clk_s, clk_d;
  logic          dat_m, dat_s;
  logic          fall;
  state_t        state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic          parity_ok;
  logic          ext, brk;
  logic [TW-1:0] tcnt;
  logic [4:0]    lut;

  // Synchronizer flops idle high so reset never fabricates a falling edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_m <= 1'b1;
      clk_s <= 1'b1;
      clk_d <= 1'b1;
      dat_m <= 1'b1;
      dat_s <= 1'b1;
    end else begin
      clk_m <= ps2_clk;
      clk_s <= clk_m;
      clk_d <= clk_s;
      dat_m <= ps2_dat;
      dat_s <= dat_m;
    end
  end

  assign fall = clk_d & ~clk_s;

  always_comb begin
    lut = 5'b00000;
    if (ext) begin
      case (shreg)
        8'h75:   lut = 5'b00010;
        8'h6B:   lut = 5'b00100;
        8'h72:   lut = 5'b01000;
        8'h74:   lut = 5'b10000;
        default: lut = 5'b00000;
      endcase
    end else begin
      case (shreg)
        8'h1D:   lut = 5'b00010;
        8'h1C:   lut = 5'b00100;
        8'h1B:   lut = 5'b01000;
        8'h23:   lut = 5'b10000;
        default: lut = 5'b00000;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= 8'h00;
      bit_cnt   <= 3'd0;
      parity_ok <= 1'b0;
      ext       <= 1'b0;
      brk       <= 1'b0;
      tcnt      <= '0;
      direction <= 5'b00000;
      dir_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      dir_valid <= 1'b0;
      frame_err <= 1'b0;

      if (state == IDLE || fall) begin
        tcnt <= '0;
      end else if (tcnt != T_LAST) begin
        tcnt <= tcnt + TW'(1);
      end

      // A falling edge always beats a coincident timeout.
      if (fall) begin
        case (state)
          IDLE: begin
            if (!dat_s) begin
              state   <= DATA;
              bit_cnt <= 3'd0;
            end
          end
          DATA: begin
            shreg   <= {dat_s, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            parity_ok <= ^{shreg, dat_s};
            state     <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (dat_s && parity_ok) begin
              if (shreg == 8'hE0) begin
                ext <= 1'b1;
              end else if (shreg == 8'hF0) begin
                brk <= 1'b1;
              end else begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (!brk && lut != 5'b00000) begin
                  direction <= lut;
                  dir_valid <= 1'b1;
                end
              end
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && tcnt == T_LAST) begin
        state     <= IDLE;
        frame_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// tb/tb_ps2_direction_decoder.sv - self-checking bench for ps2_direction_decoder
// Table of frames with expected direction and pulse counts, plus hand-written corner sequences.
module tb_ps2_direction_decoder;
  localparam int TO = 10000;
  localparam int H  = 40;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [4:0] direction;
  logic       dir_valid;
  logic       frame_err;

  int errors = 0;
  int checks = 0;
  int dv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  logic dv2, dv3;

  typedef struct {
    logic [7:0] b;
    bit         flip;
    logic [4:0] dir;
    int         dv;
    int         fe;
  } vec_t;

  vec_t vecs[$];

  ps2_direction_decoder #(.TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .direction (direction),
    .dir_valid (dir_valid),
    .frame_err (frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset) begin
      if (dir_valid) dv_cnt++;
      if (frame_err) fe_cnt++;
      if (dir_valid && frame_err) both_cnt++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends the first nbits of a frame; optionally samples dir_valid 2 and 3 edges after the stop fall.
  task automatic send_frame(input logic [7:0] b, input bit flip, input int nbits, input bit lat);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && lat) begin
        repeat (2) @(posedge clk);
        #1 dv2 = dir_valid;
        @(posedge clk);
        #1 dv3 = dir_valid;
        repeat (H - 3) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  initial begin
    int dv0, fe0;

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset_direction", 32'(direction), 32'h0);
    check("reset_dir_valid", 32'(dir_valid), 32'h0);
    check("reset_frame_err", 32'(frame_err), 32'h0);

    // Extended make with latency measurement
    dv0 = dv_cnt;
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    check("e0_no_output", 32'(dv_cnt - dv0), 32'd0);
    send_frame(8'h75, 1'b0, 11, 1'b1);
    check("latency_edge2_low", 32'(dv2), 32'd0);
    check("latency_edge3_high", 32'(dv3), 32'd1);
    check("ext_up_direction", 32'(direction), 32'h02);
    check("ext_up_pulses", 32'(dv_cnt - dv0), 32'd1);

    vecs.push_back('{8'hE0, 1'b0, 5'b00010, 0, 0});
    vecs.push_back('{8'h6B, 1'b0, 5'b00100, 1, 0});
    vecs.push_back('{8'hE0, 1'b0, 5'b00100, 0, 0});
    vecs.push_back('{8'h74, 1'b0, 5'b10000, 1, 0});
    vecs.push_back('{8'hE0, 1'b0, 5'b10000, 0, 0});
    vecs.push_back('{8'hF0, 1'b0, 5'b10000, 0, 0});
    vecs.push_back('{8'h74, 1'b0, 5'b10000, 0, 0});
    vecs.push_back('{8'h1B, 1'b0, 5'b01000, 1, 0});
    vecs.push_back('{8'h1D, 1'b1, 5'b01000, 0, 1});
    vecs.push_back('{8'h1C, 1'b0, 5'b00100, 1, 0});
    vecs.push_back('{8'h2A, 1'b0, 5'b00100, 0, 0});
    vecs.push_back('{8'hE0, 1'b0, 5'b00100, 0, 0});
    vecs.push_back('{8'h11, 1'b0, 5'b00100, 0, 0});
    vecs.push_back('{8'h1D, 1'b0, 5'b00010, 1, 0});
    vecs.push_back('{8'h1D, 1'b0, 5'b00010, 1, 0});
    vecs.push_back('{8'h1D, 1'b0, 5'b00010, 1, 0});

    foreach (vecs[k]) begin
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send_frame(vecs[k].b, vecs[k].flip, 11, 1'b0);
      check($sformatf("vec%0d_%h_direction", k, vecs[k].b), 32'(direction), 32'(vecs[k].dir));
      check($sformatf("vec%0d_%h_dir_valid", k, vecs[k].b), 32'(dv_cnt - dv0), 32'(vecs[k].dv));
      check($sformatf("vec%0d_%h_frame_err", k, vecs[k].b), 32'(fe_cnt - fe0), 32'(vecs[k].fe));
    end

    // Timeout: clock stops after 5 bits
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h23, 1'b0, 5, 1'b0);
    repeat (TO + 10) @(negedge clk);
    check("timeout_frame_err", 32'(fe_cnt - fe0), 32'd1);
    check("timeout_no_dir_valid", 32'(dv_cnt - dv0), 32'd0);
    check("timeout_direction_held", 32'(direction), 32'h02);
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h23, 1'b0, 11, 1'b0);
    check("after_timeout_direction", 32'(direction), 32'h10);
    check("after_timeout_dir_valid", 32'(dv_cnt - dv0), 32'd1);
    check("after_timeout_frame_err", 32'(fe_cnt - fe0), 32'd0);

    // Reset mid-prefix and mid-frame
    send_frame(8'hE0, 1'b0, 11, 1'b0);
    send_frame(8'h75, 1'b0, 5, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_direction", 32'(direction), 32'h0);
    check("midreset_dir_valid", 32'(dir_valid), 32'h0);
    check("midreset_frame_err", 32'(frame_err), 32'h0);
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h75, 1'b0, 11, 1'b0);
    check("post_reset_75_dir_valid", 32'(dv_cnt - dv0), 32'd0);
    check("post_reset_75_frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("post_reset_75_direction", 32'(direction), 32'h0);

    check("never_both_pulses", 32'(both_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
